read_capture: RTL



---
 rtl/read_capture.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/read_capture.sv
// rtl/read_capture.sv - DFI read-data capture and host/periodic steering (optional stats: RD_CAPTURE_STATS_EN)
module read_capture #(
   parameter int DQ_WIDTH   = 64,
   parameter int TAG_DEPTH  = 16,
   parameter int DATA_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        dfi_rddata_en,
   input  logic                        dfi_rddata_en_odd,
   input  logic                        dfi_rddata_valid,
   input  logic [4*DQ_WIDTH-1:0]       dfi_rddata,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic [4*DQ_WIDTH-1:0]       rd_data,
   output logic                        rd_last,
   output logic                        pr_rddata_valid,
   output logic [4*DQ_WIDTH-1:0]       pr_rddata,
   output logic                        pr_rddata_last,
   output logic [$clog2(TAG_DEPTH):0]  outstanding,
   output logic                        err_orphan,
   output logic                        err_overflow,
   input  logic                        err_clr,
   output logic [15:0]                 stat_host_rd,
   output logic [15:0]                 stat_pr_rd
);

   localparam int BW  = 4*DQ_WIDTH;
   localparam int TAW = $clog2(TAG_DEPTH);
   localparam int DAW = $clog2(DATA_DEPTH);

   localparam logic [0:0] BEAT0 = 1'b0;
   localparam logic [0:0] BEAT1 = 1'b1;

   logic [0:0]           beat_q, beat_d;
   logic [TAW:0]         tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
   logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
   logic [DAW:0]         dat_wptr_q, dat_wptr_d, dat_rptr_q, dat_rptr_d;
   logic [BW:0]          dat_mem_q [DATA_DEPTH];
   logic                 pr_valid_q, pr_valid_d, pr_last_q, pr_last_d;
   logic [BW-1:0]        pr_data_q, pr_data_d;
   logic                 err_orphan_q, err_orphan_d, err_overflow_q, err_overflow_d;

   logic tag_empty, tag_full, head_tag, beat_ok, orphan;
   logic host_beat, pr_beat, tag_pop, tag_push, tag_ovf;
   logic dat_empty, dat_full, dat_wr, dat_rd, dat_ovf, is_last;

   // FIFO status, routing decisions and next-state for pointers, FSM and pr port
   always_comb begin
      tag_empty = (tag_wptr_q == tag_rptr_q);
      tag_full  = (tag_wptr_q[TAW] != tag_rptr_q[TAW]) &&
                  (tag_wptr_q[TAW-1:0] == tag_rptr_q[TAW-1:0]);
      dat_empty = (dat_wptr_q == dat_rptr_q);
      dat_full  = (dat_wptr_q[DAW] != dat_rptr_q[DAW]) &&
                  (dat_wptr_q[DAW-1:0] == dat_rptr_q[DAW-1:0]);

      // head tag comes from registered state only, so a same-cycle push is never seen
      head_tag  = tag_mem_q[tag_rptr_q[TAW-1:0]];
      is_last   = (beat_q == BEAT1);
      orphan    = dfi_rddata_valid & tag_empty;
      beat_ok   = dfi_rddata_valid & ~tag_empty;
      host_beat = beat_ok & ~head_tag;
      pr_beat   = beat_ok & head_tag;

      tag_pop   = beat_ok & is_last;
      // a full FIFO still accepts a push when a pop frees a slot in the same cycle
      tag_push  = dfi_rddata_en & (~tag_full | tag_pop);
      tag_ovf   = dfi_rddata_en & tag_full & ~tag_pop;

      dat_wr    = host_beat & ~dat_full;
      dat_ovf   = host_beat & dat_full;
      dat_rd    = ~dat_empty & rd_ready;

      tag_mem_d = tag_mem_q;
      if (tag_push)
         tag_mem_d[tag_wptr_q[TAW-1:0]] = dfi_rddata_en_odd;
      tag_wptr_d = tag_wptr_q + (tag_push ? 1'b1 : 1'b0);
      tag_rptr_d = tag_rptr_q + (tag_pop  ? 1'b1 : 1'b0);
      dat_wptr_d = dat_wptr_q + (dat_wr   ? 1'b1 : 1'b0);
      dat_rptr_d = dat_rptr_q + (dat_rd   ? 1'b1 : 1'b0);

      // orphan beats still advance the FSM so burst alignment is kept
      beat_d = beat_q;
      if (dfi_rddata_valid)
         beat_d = (beat_q == BEAT0) ? BEAT1 : BEAT0;

      pr_valid_d = pr_beat;
      pr_last_d  = pr_beat & is_last;
      pr_data_d  = pr_beat ? dfi_rddata : '0;

      // clear wins over a same-cycle set; that new error is lost
      if (err_clr) begin
         err_orphan_d   = 1'b0;
         err_overflow_d = 1'b0;
      end else begin
         err_orphan_d   = err_orphan_q | orphan;
         err_overflow_d = err_overflow_q | tag_ovf | dat_ovf;
      end
   end

   // control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q         <= BEAT0;
         tag_wptr_q     <= '0;
         tag_rptr_q     <= '0;
         tag_mem_q      <= '0;
         dat_wptr_q     <= '0;
         dat_rptr_q     <= '0;
         pr_valid_q     <= 1'b0;
         pr_last_q      <= 1'b0;
         pr_data_q      <= '0;
         err_orphan_q   <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         beat_q         <= beat_d;
         tag_wptr_q     <= tag_wptr_d;
         tag_rptr_q     <= tag_rptr_d;
         tag_mem_q      <= tag_mem_d;
         dat_wptr_q     <= dat_wptr_d;
         dat_rptr_q     <= dat_rptr_d;
         pr_valid_q     <= pr_valid_d;
         pr_last_q      <= pr_last_d;
         pr_data_q      <= pr_data_d;
         err_orphan_q   <= err_orphan_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   // host beat storage; contents need no reset since reads are gated by the pointers
   always_ff @(posedge clk) begin
      if (dat_wr)
         dat_mem_q[dat_wptr_q[DAW-1:0]] <= {is_last, dfi_rddata};
   end

   // host port shows the FIFO head, forced to zero while empty
   always_comb begin
      rd_valid = ~dat_empty;
      if (dat_empty)
         {rd_last, rd_data} = '0;
      else
         {rd_last, rd_data} = dat_mem_q[dat_rptr_q[DAW-1:0]];
   end

   assign pr_rddata_valid = pr_valid_q;
   assign pr_rddata       = pr_data_q;
   assign pr_rddata_last  = pr_last_q;
   assign outstanding     = tag_wptr_q - tag_rptr_q;
   assign err_orphan      = err_orphan_q;
   assign err_overflow    = err_overflow_q;

`ifdef RD_CAPTURE_STATS_EN
   logic [15:0] stat_host_q, stat_host_d, stat_pr_q, stat_pr_d;

   // saturating burst counters, bumped on each completing tag pop
   always_comb begin
      stat_host_d = stat_host_q;
      stat_pr_d   = stat_pr_q;
      if (err_clr) begin
         stat_host_d = '0;
         stat_pr_d   = '0;
      end else if (tag_pop) begin
         if (!head_tag && stat_host_q != 16'hFFFF)
            stat_host_d = stat_host_q + 16'd1;
         if (head_tag && stat_pr_q != 16'hFFFF)
            stat_pr_d = stat_pr_q + 16'd1;
      end
   end

   // counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_host_q <= '0;
         stat_pr_q   <= '0;
      end else begin
         stat_host_q <= stat_host_d;
         stat_pr_q   <= stat_pr_d;
      end
   end

   assign stat_host_rd = stat_host_q;
   assign stat_pr_rd   = stat_pr_q;
`else
   assign stat_host_rd = '0;
   assign stat_pr_rd   = '0;
`endif

endmodule
